// File: rtl/ultrasonic_pkg.sv
// Shared constants and FSM encoding for the ultrasonic trigger/echo path.
package ultrasonic_pkg;

  localparam int unsigned DEF_CLK_HZ        = 50_000_000;
  localparam int unsigned DEF_CYCLES_PER_CM = 2900;
  localparam int unsigned DEF_MAX_CM        = 400;
  localparam int unsigned DEF_RISE_TIMEOUT  = 1_000_000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_DONE
  } echo_state_t;

endpackage

// File: rtl/echo_sync_edge.sv
// Two-flop synchroniser for the raw ECHO pin with registered rise/fall pulses.
module echo_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic echo,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;

  // Both pulses trail the pin by the same two cycles, so widths are preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= echo;
      sync2 <= sync1;
      rise  <= sync1 & ~sync2;
      fall  <= ~sync1 & sync2;
    end
  end

endmodule

// File: rtl/ultrasonic_echo_meter.sv
// Measures ECHO high time after each start and converts it to whole cm by
// counting CYCLES_PER_CM-cycle slices; flags no-echo timeout and over-range.
module ultrasonic_echo_meter
  import ultrasonic_pkg::*;
#(
  parameter int unsigned CYCLES_PER_CM = DEF_CYCLES_PER_CM,
  parameter int unsigned MAX_CM        = DEF_MAX_CM,
  parameter int unsigned RISE_TIMEOUT  = DEF_RISE_TIMEOUT,
  parameter int unsigned DIST_W        = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              echo,
  output logic              busy,
  output logic              valid,
  output logic [DIST_W-1:0] distance_cm,
  output logic              timeout,
  output logic              overrange
);

  localparam int unsigned TMO_W = (RISE_TIMEOUT > 1) ? $clog2(RISE_TIMEOUT) : 1;
  localparam int unsigned PRE_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(RISE_TIMEOUT - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CYCLES_PER_CM - 1);
  localparam logic [DIST_W-1:0] CM_MAX   = DIST_W'(MAX_CM);

  echo_state_t       state, state_next;
  logic [TMO_W-1:0]  tmo_cnt, tmo_next;
  logic [PRE_W-1:0]  pre_cnt, pre_next;
  logic [DIST_W-1:0] cm_cnt, cm_next;
  logic              rise, fall;
  logic              wrap;
  logic              load;
  logic [DIST_W-1:0] res_dist;
  logic              res_tmo;
  logic              res_ovr;

  echo_sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .echo  (echo),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
      pre_cnt <= '0;
      cm_cnt  <= '0;
    end else begin
      state   <= state_next;
      tmo_cnt <= tmo_next;
      pre_cnt <= pre_next;
      cm_cnt  <= cm_next;
    end
  end

  always_comb begin
    state_next = state;
    tmo_next   = tmo_cnt;
    pre_next   = pre_cnt;
    cm_next    = cm_cnt;
    wrap       = 1'b0;
    load       = 1'b0;
    res_dist   = '0;
    res_tmo    = 1'b0;
    res_ovr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_WAIT_RISE;
          tmo_next   = '0;
          pre_next   = '0;
          cm_next    = '0;
        end
      end
      ST_WAIT_RISE: begin
        tmo_next = tmo_cnt + 1'b1;
        if (rise) begin
          state_next = ST_MEASURE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = ST_DONE;
          load       = 1'b1;
          res_tmo    = 1'b1;
        end
      end
      ST_MEASURE: begin
        // The fall cycle itself still counts, keeping the total equal to the high time.
        wrap     = (pre_cnt == PRE_LAST);
        pre_next = wrap ? '0 : pre_cnt + 1'b1;
        if (wrap && (cm_cnt != CM_MAX)) begin
          cm_next = cm_cnt + 1'b1;
        end
        if (fall) begin
          state_next = ST_DONE;
          load       = 1'b1;
          res_dist   = cm_next;
        end else if (wrap && (cm_cnt == CM_MAX)) begin
          state_next = ST_DONE;
          load       = 1'b1;
          res_dist   = CM_MAX;
          res_ovr    = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Results are captured on entry to DONE, so valid is high exactly while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid       <= 1'b0;
      distance_cm <= '0;
      timeout     <= 1'b0;
      overrange   <= 1'b0;
    end else begin
      valid <= load;
      if (load) begin
        distance_cm <= res_dist;
        timeout     <= res_tmo;
        overrange   <= res_ovr;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
